regfile_param: RTL
==================

# regfile_param

Parametrised integer register file for the RISC-V core pipeline: configurable data width, depth and read-port count, two write ports, and a debug tap that generalises the fixed seven-segment register output. Instead of a one-cycle bulk reset, the storage array is zeroed by a sequential sweep after reset or on request, with a `ready` flag gating use. Sits in the decode stage (reads) and writeback stage (writes).

## Interface
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 5, address width; depth = 2**ADDR_W
- `NUM_RD`, 2, number of combinational read ports (1..4)
- `ZERO_REG`, 1, when 1, address 0 always reads 0 and ignores writes

- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `clear_req`  in  1  one-cycle pulse: start a zeroing sweep
- `ready`  out  1  high when the array is valid and writable
- `rd_addr`  in  NUM_RD*ADDR_W  packed read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- `rd_data`  out  NUM_RD*DATA_W  packed read data, same packing
- `we0`, `we1`  in  1  write enables, ports 0/1
- `wa0`, `wa1`  in  ADDR_W  write addresses
- `wd0`, `wd1`  in  DATA_W  write data
- `dbg_addr`  in  ADDR_W  debug tap address
- `dbg_data`  out  DATA_W  debug tap data (combinational read, no bypass)

## Operation
- FSM states: SWEEP, READY. Async reset → SWEEP, sweep counter = 0, `ready` = 0.
- SWEEP: each cycle writes 0 to row `counter`, counter increments; after row DEPTH-1 written, next state READY. Sweep takes exactly DEPTH cycles.
- READY: `clear_req` = 1 → SWEEP with counter = 0 next cycle. `clear_req` in SWEEP is ignored (no restart).
- Writes (`we0`/`we1`) are dropped while in SWEEP. In READY, a write occurs when enable = 1 and (address ≠ 0 or ZERO_REG = 0).
- Both ports writing the same address in one cycle: port 1 wins.
- `clear_req` and a write in the same READY cycle: write is performed, then the sweep overwrites it.
- Reads: `rd_data[i]` = array[rd_addr[i]]; forced to 0 when `ready` = 0, and when address = 0 with ZERO_REG = 1.
- `dbg_data` follows the same zero-forcing rules as read ports but never bypasses.
- Reset asserted mid-sweep or mid-operation: immediately SWEEP, counter 0, `ready` low; array contents undefined until the sweep completes (masked by read zero-forcing).

## Timing
- Reset values: `ready` = 0, all `rd_data` = 0, `dbg_data` = 0.
- `ready` rises DEPTH cycles after the first rising edge with `rst_n` high (32 for ADDR_W = 5); it falls the cycle after an accepted `clear_req`.
- Write-to-read latency: 1 cycle (value visible after the capturing edge) without bypass; 0 cycles with bypass.
- Read ports are purely combinational from `rd_addr` and array state.

## Configuration
- `REGFILE_BYPASS_EN` defined: a read port whose address matches an active, legal write in the same cycle returns that write data combinationally (port 1 priority over port 0). `dbg_data` is unaffected.
- Undefined: a read of an address being written returns the old array value; the new value is visible the next cycle.

## Test plan
- Reset release → `ready` = 0 for 32 cycles, then 1; all 32 rows read 0 via `rd_data` and `dbg_data`.
- READY: `we0`=1, `wa0`=5, `wd0`=0xDEADBEEF; next cycle `rd_addr` port 0 = 5 → 0xDEADBEEF; write to address 0 → reads remain 0.
- Same cycle: `we0`/`we1` both to address 7 with 0x11 / 0x22 → address 7 reads 0x22; with REGFILE_BYPASS_EN, the same-cycle read of 7 returns 0x22; without it, it returns the previous value.
- Write 0x1234 to address 12, pulse `clear_req` → `ready` low for 32 cycles, writes during the sweep are dropped, and address 12 reads 0 afterward.
- Assert `rst_n` low at sweep cycle 10 → `ready` stays 0, the counter restarts, and `ready` rises 32 cycles after release.
- NUM_RD = 4, ZERO_REG = 0: all four ports read independent addresses correctly, and address 0 holds a written 0xA5.

Source files
------------

// File: rtl/regfile_param.sv
// regfile_param: parametrised integer register file for the core pipeline.
// Two write ports (port 1 wins on a same-address collision), NUM_RD
// combinational read ports and a debug tap. After reset or clear_req the
// array is zeroed by a one-row-per-cycle sweep; `ready` gates reads/writes.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read bypass
// on the read ports; the debug tap never bypasses).
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_req,
  output logic                     ready,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd0,
  input  logic [DATA_W-1:0]        wd1,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam int DEPTH = 32'sd1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ROW = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(32'd1);

  typedef enum logic [0:0] {
    ST_SWEEP = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic wr0_ok;
  logic wr1_ok;

  // A write is legal only in READY and never to row 0 when it is hard-wired.
  assign wr0_ok = (state_q == ST_READY) && we0 && ((wa0 != {ADDR_W{1'b0}}) || !ZERO_REG);
  assign wr1_ok = (state_q == ST_READY) && we1 && ((wa1 != {ADDR_W{1'b0}}) || !ZERO_REG);

  assign ready = (state_q == ST_READY);

  // Next-state logic: sweep rows 0..DEPTH-1 then idle in READY until clear_req.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_SWEEP: begin
        if (cnt_q == LAST_ROW) begin
          state_d = ST_READY;
          cnt_d   = {ADDR_W{1'b0}};
        end else begin
          state_d = ST_SWEEP;
          cnt_d   = cnt_q + ONE_A;
        end
      end
      ST_READY: begin
        if (clear_req) begin
          state_d = ST_SWEEP;
          cnt_d   = {ADDR_W{1'b0}};
        end else begin
          state_d = ST_READY;
          cnt_d   = cnt_q;
        end
      end
      default: begin
        state_d = ST_SWEEP;
        cnt_d   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // FSM and sweep counter registers; reset restarts the sweep from row 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SWEEP;
      cnt_q   <= {ADDR_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Per-row next value: sweep zeroing, else port 1, else port 0, else hold.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      if ((state_q == ST_SWEEP) && (cnt_q == ADDR_W'(r))) begin
        mem_d[r] = {DATA_W{1'b0}};
      end else if (wr1_ok && (wa1 == ADDR_W'(r))) begin
        mem_d[r] = wd1;
      end else if (wr0_ok && (wa0 == ADDR_W'(r))) begin
        mem_d[r] = wd0;
      end else begin
        mem_d[r] = mem_q[r];
      end
    end
  end

  // Storage array; deliberately not reset, the sweep provides the clean state.
  always_ff @(posedge clk) begin
    for (int r = 0; r < DEPTH; r++) begin
      mem_q[r] <= mem_d[r];
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] data_s;

    assign addr_s = rd_addr[i*ADDR_W +: ADDR_W];

    // Read port: zero while not ready or on hard-wired row 0, optional bypass.
    always_comb begin
      data_s = {DATA_W{1'b0}};
      if (!ready) begin
        data_s = {DATA_W{1'b0}};
      end else if (ZERO_REG && (addr_s == {ADDR_W{1'b0}})) begin
        data_s = {DATA_W{1'b0}};
`ifdef REGFILE_BYPASS_EN
      end else if (wr1_ok && (wa1 == addr_s)) begin
        data_s = wd1;
      end else if (wr0_ok && (wa0 == addr_s)) begin
        data_s = wd0;
`endif
      end else begin
        data_s = mem_q[addr_s];
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = data_s;
  end

  // Debug tap: same zero-forcing as the read ports, never bypassed.
  always_comb begin
    dbg_data = {DATA_W{1'b0}};
    if (!ready) begin
      dbg_data = {DATA_W{1'b0}};
    end else if (ZERO_REG && (dbg_addr == {ADDR_W{1'b0}})) begin
      dbg_data = {DATA_W{1'b0}};
    end else begin
      dbg_data = mem_q[dbg_addr];
    end
  end

endmodule
